// File: rtl/alu_wide_seq_if.sv
// Request/response bundle between a requester and the wide ALU sequencer.
interface alu_wide_seq_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = N * WORDS;

    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         sign;
    logic         zero;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, resp_ready,
        input  req_ready, resp_valid, result, carry, overflow, sign, zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, resp_ready,
        output req_ready, resp_valid, result, carry, overflow, sign, zero
    );
endinterface

// File: rtl/alu_wide_seq.sv
// Multi-precision add/sub/compare built by stepping one narrow ALU across WORDS words,
// least-significant word first, with the carry chained through a register.

`ifndef ALU_ADD
`define ALU_ADD 2'd0
`endif

// Narrow ALU: 0=ADD, 1=SUB, 2=AND, 3=OR. Only ADD is used by the sequencer.
module alu #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    input  logic         cin,
    output logic [N-1:0] out,
    output logic         cout,
    output logic         overflow
);
    logic [N-1:0] bb;
    logic [N:0]   sum;

    // Adder with optional B inversion; logic ops report no carry/overflow.
    always_comb begin
        bb       = (op == 2'd1) ? ~b : b;
        sum      = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, cin};
        out      = sum[N-1:0];
        cout     = sum[N];
        overflow = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
        if (op == 2'd2) begin
            out      = a & b;
            cout     = 1'b0;
            overflow = 1'b0;
        end else if (op == 2'd3) begin
            out      = a | b;
            cout     = 1'b0;
            overflow = 1'b0;
        end
    end
endmodule

module alu_wide_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_wide_seq_if.slave bus
);
    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WORDS - 1);

    localparam logic [1:0] OpAdd = 2'd0;
    localparam logic [1:0] OpSub = 2'd1;
    localparam logic [1:0] OpAdc = 2'd2;
    localparam logic [1:0] OpCmp = 2'd3;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            cy_q, cy_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_q, work_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic            sign_q, sign_d;
    logic            zero_q, zero_d;

    logic [N-1:0]    alu_a, alu_b, alu_out;
    logic [1:0]      alu_op;
    logic            alu_cin, alu_cout, alu_ovf;

    alu #(.N(N)) u_alu (
        .a       (alu_a),
        .b       (alu_b),
        .op      (alu_op),
        .cin     (alu_cin),
        .out     (alu_out),
        .cout    (alu_cout),
        .overflow(alu_ovf)
    );

    // Next-state, datapath updates and ALU drive.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cy_d     = cy_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = `ALU_ADD;
        alu_cin  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d   = bus.req_op;
                    a_d    = bus.req_a;
                    // Subtraction is A + ~B + 1, so invert B once at capture.
                    b_d    = (bus.req_op == OpSub || bus.req_op == OpCmp) ? ~bus.req_b
                                                                          : bus.req_b;
                    unique case (bus.req_op)
                        OpAdd:   cy_d = 1'b0;
                        OpAdc:   cy_d = bus.req_cin;
                        default: cy_d = 1'b1;
                    endcase
                    idx_d   = '0;
                    work_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                alu_a   = a_q[idx_q*N +: N];
                alu_b   = b_q[idx_q*N +: N];
                alu_cin = cy_q;
                work_d[idx_q*N +: N] = alu_out;
                cy_d  = alu_cout;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == IdxLast) begin
                    idx_d   = '0;
                    carry_d = alu_cout;
                    ovf_d   = alu_ovf;
                    sign_d  = work_d[W-1];
                    zero_d  = (work_d == '0);
                    // Compare only reports flags; the visible result is left alone.
                    if (op_q != OpCmp) result_d = work_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cy_q     <= 1'b0;
            op_q     <= OpAdd;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cy_q     <= cy_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StDone);
    assign bus.result     = result_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = ovf_q;
    assign bus.sign       = sign_q;
    assign bus.zero       = zero_q;
endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
Multi-precision arithmetic sequencer that time-shares a single n-bit `alu` instance to add, subtract or compare operands WORDS times wider than the ALU.
- Processes one word per clock, least-significant word first, chaining the ALU carry between words.
- Sits between a requester with a valid/ready request/response interface and the ALU.
- Is the only driver of the ALU's a/b/op/cin inputs.

Parameters:
N, 8, ALU word width (passed to `alu #(N)`)
WORDS, 4, number of words per operand; total width W = N*WORDS; WORDS >= 2

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_op  input  2  0=ADD, 1=SUB, 2=ADC (add with carry_in), 3=CMP (SUB, flags only)
req_a  input  W  operand A
req_b  input  W  operand B
req_cin  input  1  carry in, used only by ADC
resp_valid  output  1  result and flags valid
resp_ready  input  1  consumer accepts the response
result  output  W  wide result
carry  output  1  final ALU cout (for SUB/CMP: 1 = no borrow, i.e. A >= B unsigned)
overflow  output  1  signed overflow, taken from the top word's ALU overflow
sign  output  1  result bit W-1
zero  output  1  all W result bits zero

Behaviour:
- States: IDLE, RUN, DONE. Word index counter idx, width clog2(WORDS), plus a carry register.
- Reset (async, any state):
  - state=IDLE, idx=0, carry register=0.
  - result=0, carry=0, overflow=0, sign=0, zero=0, resp_valid=0.
  - req_ready=1 once rst_n is high.
  - A reset mid-RUN abandons the operation; no response is produced.
- IDLE:
  - req_ready=1.
  - On req_valid at a rising edge, the block does the following on that edge (E0):
    - latches op, A and B; B is stored as ~req_b for SUB/CMP.
    - initialises the carry register: ADD=0, SUB/CMP=1, ADC=req_cin.
    - sets idx=0 and moves to RUN.
  - For CMP, a working copy of the result is cleared internally. The `result` output keeps its previous value.
- RUN:
  - req_ready=0.
  - ALU is driven with op=`ALU_ADD`, a=A word idx, b=stored B word idx, cin=carry register.
  - Requirement on `alu`: ADD computes a+b+cin, and cout/overflow reflect that sum.
  - At each edge:
    - the ALU out is written to working result word idx.
    - the carry register takes cout.
    - idx increments.
  - At the edge where idx=WORDS-1, the block also:
    - captures overflow from the ALU.
    - computes sign and zero over the full working result, including the word being written.
    - moves to DONE.
- Latency: a request accepted at edge E0 produces resp_valid=1 immediately after edge E0+WORDS.
- DONE:
  - resp_valid=1; result and flags are stable and held while resp_ready=0, for any number of cycles.
  - `result` is updated from the working copy on entry to DONE for ADD/SUB/ADC, and left unchanged for CMP. Flags are updated for all ops.
  - On resp_valid && resp_ready at an edge: resp_valid drops, state goes to IDLE, req_ready=1 in the next cycle.
  - No request is accepted on the same edge as the response handshake. Back-to-back throughput is one op per WORDS+2 cycles minimum.
- Outside RUN, ALU inputs are held at 0 and op=`ALU_ADD`; ALU outputs are ignored.
- req_a, req_b and req_op may change freely after acceptance without affecting the operation in flight.
- Wrap-around: the result is modulo 2^W. carry exposes the unsigned carry-out or borrow; overflow exposes the signed overflow.

Test Plan:
- N=8, WORDS=4. ADD A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, carry=1, zero=1, sign=0, overflow=0; resp_valid rises exactly 4 edges after acceptance.
- SUB A=0x80000000, B=0x00000001 -> result=0x7FFFFFFF, carry=1, overflow=1, sign=0, zero=0. SUB A=1, B=2 -> result=0xFFFFFFFF, carry=0, sign=1, overflow=0.
- ADC A=0x7FFFFFFF, B=0, cin=1 -> result=0x80000000, overflow=1, sign=1, carry=0. ADD 0x000000FF+0x00000001 -> 0x00000100, proving the inter-word carry chain.
- CMP A=0x12345678, B=0x12345678, issued after an ADD that left result=0x00000100 -> result stays 0x00000100, zero=1, carry=1, sign=0.
- Hold resp_ready=0 for 5 cycles in DONE, with req_valid=1 and a new request on the bus -> resp_valid, result and flags stable, req_ready=0. Release -> the new request is accepted no earlier than the cycle after the response handshake.
- Assert rst_n=0 for one cycle mid-RUN (idx=2) -> all outputs read 0 immediately (async), req_ready=1 after release, no resp_valid. The next ADD 3+4 -> result 7.
